mod_updown_counter: RTL
=======================

// Module: mod_updown_counter
// PURPOSE
//  Parametrised successor to the free-running up counter. Adds a runtime modulus,
//  up/down direction, count enable, synchronous clear and parallel load, a
//  wrap-or-saturate mode, and an optional built-in prescaler.
//  Used for timers, event counters and cascaded multi-digit counters.
//  tc is the carry/borrow that feeds the next stage's en.
// PARAMETERS
//  BITS      4   counter width
//  MODE      0   0 = wrap at the terminal value, 1 = saturate (hold) at the terminal value
//  PRESCALE  1   counter advances once every PRESCALE enabled cycles; 1 = no prescaler
// PORTS
//  clk        in   1     rising-edge clock, single clock domain
//  reset_n    in   1     synchronous, active-low reset
//  clear      in   1     synchronous clear of Q, ovf and the prescaler
//  load       in   1     parallel load strobe
//  load_val   in   BITS  value to load
//  en         in   1     count enable
//  up         in   1     1 = count up, 0 = count down
//  final_val  in   BITS  top value; count range is 0..final_val
//  Q          out  BITS  registered count
//  tc         out  1     combinational terminal-count/carry
//  ovf        out  1     registered sticky flag: a count was attempted at a bound
// BEHAVIOUR
//  - All state updates on the rising edge of clk.
//  - Priority, highest first: reset_n=0 > clear > load > step > hold.
//  - reset_n=0 at an edge: Q=0, ovf=0, prescaler=0. Applies even mid-count or mid-load.
//  - clear=1: same effect as reset.
//  - load=1: Q <= min(load_val, final_val). Prescaler <= 0. ovf unchanged.
//  - step = en & tick.
//    - tick = 1 when PRESCALE==1.
//    - Otherwise tick = (pre == PRESCALE-1).
//    - pre increments only while en=1 and wraps to 0 after PRESCALE-1.
//    - pre holds while en=0.
//  - Terminal condition:
//    - up=1: Q >= final_val. ">=" covers final_val being lowered below Q.
//    - up=0: Q == 0.
//  - On a step in the up direction:
//    - Not terminal: Q+1.
//    - Terminal, MODE0: Q <= 0.
//    - Terminal, MODE1: Q holds and ovf <= 1.
//  - On a step in the down direction:
//    - Not terminal: Q-1.
//    - Terminal, MODE0: Q <= final_val.
//    - Terminal, MODE1: Q holds and ovf <= 1.
//  - In MODE0, ovf also sets on every wrap. It is sticky until clear or reset.
//  - tc = step & terminal. Combinational, so a cascaded stage steps in the same cycle.
//    tc is forced to 0 while clear or load is active.
//  - Latency: one step is visible on Q the edge after step=1. load/clear are also one edge.
//  - final_val == 0: Q is pinned at 0. Every step is terminal, so tc=step.
//  - up may change on any cycle. No extra latency.
//  - Arithmetic is modulo 2^BITS internally. It never exceeds final_val except
//    transiently after final_val is lowered; the next step corrects it.
// STRUCTURE
//  - Package counter_pkg:
//    - localparams MODE_WRAP=0, MODE_SAT=1.
//    - Function clamp(val, top) shared with load logic in sibling timers.
//  - Sub-module prescale_tick (params N; ports clk, reset_n, clr, en, tick):
//    - Holds the pre counter of width $clog2(N).
//    - Generated only when PRESCALE > 1; otherwise tick is tied to 1.
//    - clr = clear | load.
//  - Top level: state register plus a next-state always block, separate from the output logic.
// TESTING  (BITS=4 unless noted)
//  1. Wrap up: MODE0, final_val=9, en=1, up=1, 12 clocks from reset.
//     -> Q 0..9,0,1. tc=1 only on the Q=9 cycle. ovf=1 after the wrap.
//  2. Down wrap / saturate:
//     - MODE0, final_val=5, up=0, from Q=0 -> Q 5,4,3.
//     - MODE1, same stimulus -> Q stays 0, ovf=1, tc=1 each step.
//  3. Priority: load=1 with load_val=12, final_val=7, en=1, clear=0 -> Q=7.
//     Same cycle with clear=1 -> Q=0, ovf=0.
//  4. Prescaler: PRESCALE=3, en=1, up=1 -> Q increments every 3rd clock.
//     Drop en for 2 cycles mid-period -> the phase is preserved.
//  5. Reset mid-operation: reset_n=0 for 1 cycle at Q=6, pre=1
//     -> next edge Q=0, pre=0, ovf=0. Counting resumes with a full PRESCALE period.
//  6. Lower final_val from 15 to 4 while Q=10, up=1
//     -> next step gives Q=0 (MODE0) or Q holds at 10 with ovf=1 (MODE1).

Source files
------------

// File: rtl/mod_updown_counter_pkg.sv
// Shared definitions for the up/down counter family: mode encodings and
// the load-value clamp used by this counter and its sibling timers.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Widest operand the clamp helper handles; callers cast down to their width.
  localparam int CLAMP_W = 32;

  // Limit a requested value to the top of the count range.
  function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] val,
                                               input logic [CLAMP_W-1:0] top);
    return (val > top) ? top : val;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of the up/down counter. The master side drives the
// strobes and configuration; the slave side (the counter) returns Q, tc, ovf.
interface mod_updown_counter_if #(
  parameter int BITS = 4
);

  logic            clear;
  logic            load;
  logic [BITS-1:0] load_val;
  logic            en;
  logic            up;
  logic [BITS-1:0] final_val;
  logic [BITS-1:0] Q;
  logic            tc;
  logic            ovf;

  modport master (
    output clear, load, load_val, en, up, final_val,
    input  Q, tc, ovf
  );

  modport slave (
    input  clear, load, load_val, en, up, final_val,
    output Q, tc, ovf
  );

endinterface

// File: rtl/mod_updown_counter_prescale_tick.sv
// Prescaler for the up/down counter: produces a one-cycle tick on every
// N-th enabled cycle. The phase counter freezes while en is low so that
// gating the counter does not lose its position within a period.
module prescale_tick #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] pre_q;
  logic [W-1:0] pre_d;

  // Next phase: clear wins, otherwise advance (with wrap) only while enabled.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + W'(1);
    end
  end

  // Phase register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // The tick marks the last phase of the period; the caller qualifies it with en.
  always_comb begin
    tick = (pre_q == LAST);
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with runtime modulus (0..final_val), count
// enable, synchronous clear, parallel load, wrap-or-saturate behaviour at the
// bounds and an optional prescaler. tc is combinational so that a cascaded
// stage wired to it steps in the same cycle as this one.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int BITS     = 4,
  parameter int MODE     = MODE_WRAP,
  parameter int PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mod_updown_counter_if.slave     bus
);

  logic [BITS-1:0] q_q;
  logic [BITS-1:0] q_d;
  logic            ovf_q;
  logic            ovf_d;
  logic            tick;
  logic            step;
  logic            terminal;
  logic            tc_int;

  // Prescaler only exists when a division is asked for; otherwise every
  // enabled cycle is a step.
  generate
    if (PRESCALE > 1) begin : g_pre
      prescale_tick #(
        .N (PRESCALE)
      ) u_prescale_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (bus.clear | bus.load),
        .en      (bus.en),
        .tick    (tick)
      );
    end else begin : g_no_pre
      assign tick = 1'b1;
    end
  endgenerate

  // Step qualification and bound detection. Counting up uses >= so that a
  // count left above a freshly lowered final_val is treated as terminal.
  always_comb begin
    step     = bus.en & tick;
    terminal = bus.up ? (q_q >= bus.final_val) : (q_q == '0);
  end

  // Next-state: clear > load > step > hold. Reset is applied in the register.
  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (bus.clear) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (bus.load) begin
      q_d = BITS'(clamp(CLAMP_W'(bus.load_val), CLAMP_W'(bus.final_val)));
    end else if (step) begin
      if (!terminal) begin
        q_d = bus.up ? q_q + BITS'(1) : q_q - BITS'(1);
      end else begin
        // Any step at a bound is flagged, whether it wraps or saturates.
        ovf_d = 1'b1;
        if (MODE == MODE_WRAP) begin
          q_d = bus.up ? '0 : bus.final_val;
        end
      end
    end
  end

  // Count and sticky overflow registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  // Carry/borrow to the next stage, suppressed while clear or load own the cycle.
  always_comb begin
    tc_int = step & terminal & ~bus.clear & ~bus.load;
  end

  assign bus.Q   = q_q;
  assign bus.ovf = ovf_q;
  assign bus.tc  = tc_int;

endmodule
